// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 RGB matrix row-scan driver and its capture mirror.
package led_matrix_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [2:0] row_idx_t;

   typedef struct packed {
      logic [COLS-1:0] r;
      logic [COLS-1:0] g;
      logic [COLS-1:0] b;
   } rgb_row_t;

   typedef rgb_row_t [ROWS-1:0] frame_t;

   typedef enum logic {
      HUNT  = 1'b0,
      SWEEP = 1'b1
   } fsm_state_t;

   // Scan columns are active-low; the buffers hold lit-is-one pixels.
   function automatic rgb_row_t decode_cols(input logic [COLS-1:0] r,
                                            input logic [COLS-1:0] g,
                                            input logic [COLS-1:0] b);
      rgb_row_t px;
      px.r = ~r;
      px.g = ~g;
      px.b = ~b;
      return px;
   endfunction

endpackage

// File: rtl/led_scan_capture_if.sv
// Scan bus plus read-port bundle between a matrix scan source and the capture mirror.
interface led_scan_capture_if #(
   parameter int CNT_W = 16
);
   import led_matrix_pkg::*;

   logic            scan_en;
   row_idx_t        scan_row;
   logic [COLS-1:0] scan_r;
   logic [COLS-1:0] scan_g;
   logic [COLS-1:0] scan_b;

   row_idx_t        rd_row;
   logic [COLS-1:0] rd_r;
   logic [COLS-1:0] rd_g;
   logic [COLS-1:0] rd_b;

   logic             frame_valid;
   logic             frame_changed;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] seq_err;

   modport master (
      output scan_en, scan_row, scan_r, scan_g, scan_b, rd_row,
      input  rd_r, rd_g, rd_b, frame_valid, frame_changed, frame_count, seq_err
   );

   modport slave (
      input  scan_en, scan_row, scan_r, scan_g, scan_b, rd_row,
      output rd_r, rd_g, rd_b, frame_valid, frame_changed, frame_count, seq_err
   );

endinterface

// File: rtl/scan_settle_filter.sv
// Synchronizes the asynchronous scan bus and emits one capture strobe per
// dwell once the row/column vector has held steady long enough.
module scan_settle_filter
   import led_matrix_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            scan_en,
   input  row_idx_t        scan_row,
   input  logic [COLS-1:0] scan_r,
   input  logic [COLS-1:0] scan_g,
   input  logic [COLS-1:0] scan_b,
   output logic            en,
   output logic            capture,
   output row_idx_t        row,
   output logic [COLS-1:0] r,
   output logic [COLS-1:0] g,
   output logic [COLS-1:0] b
);

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   typedef struct packed {
      logic            en;
      row_idx_t        row;
      logic [COLS-1:0] r;
      logic [COLS-1:0] g;
      logic [COLS-1:0] b;
   } scan_vec_t;

   scan_vec_t  meta_q;
   scan_vec_t  sync_q;
   scan_vec_t  held_q;
   logic [7:0] stable_cnt;
   logic       captured;
   logic       changed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {scan_en, scan_row, scan_r, scan_g, scan_b};
         sync_q <= meta_q;
      end
   end

   // held_q is the sample being qualified; stable_cnt is how many further
   // identical samples have followed it, so a capture needs SETTLE_CYCLES in a row.
   assign changed = (sync_q != held_q) || !sync_q.en;
   assign capture = held_q.en && (stable_cnt == CNT_LAST) && !captured;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q     <= '0;
         stable_cnt <= '0;
         captured   <= 1'b0;
      end else begin
         held_q <= sync_q;
         if (changed) begin
            stable_cnt <= '0;
            captured   <= 1'b0;
         end else begin
            if (stable_cnt != CNT_LAST) begin
               stable_cnt <= stable_cnt + 8'd1;
            end
            if (capture) begin
               captured <= 1'b1;
            end
         end
      end
   end

   assign en  = held_q.en;
   assign row = held_q.row;
   assign r   = held_q.r;
   assign g   = held_q.g;
   assign b   = held_q.b;

endmodule

// File: rtl/led_scan_capture.sv
// Receive-side mirror of the 8x8 RGB row-scan bus: rebuilds whole frames from
// settled row captures and exposes the last committed frame on a read port.
module led_scan_capture
   import led_matrix_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   led_scan_capture_if.slave bus
);

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;

   logic             cap_en;
   logic             capture;
   row_idx_t         cap_row;
   logic [COLS-1:0]  cap_r;
   logic [COLS-1:0]  cap_g;
   logic [COLS-1:0]  cap_b;

   fsm_state_t       state;
   fsm_state_t       state_next;
   row_idx_t         expected;
   row_idx_t         expected_next;
   logic             seq_inc;
   logic             commit;

   frame_t           shadow;
   frame_t           shadow_upd;
   frame_t           frame;
   logic             frame_valid_q;
   logic             frame_changed_q;
   logic [CNT_W-1:0] frame_count_q;
   logic [CNT_W-1:0] seq_err_q;

   // Reset asserts immediately but is released only after two clean edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_pipe[1];

   scan_settle_filter #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_filter (
      .clk      (clk),
      .rst_n    (rst_sync_n),
      .scan_en  (bus.scan_en),
      .scan_row (bus.scan_row),
      .scan_r   (bus.scan_r),
      .scan_g   (bus.scan_g),
      .scan_b   (bus.scan_b),
      .en       (cap_en),
      .capture  (capture),
      .row      (cap_row),
      .r        (cap_r),
      .g        (cap_g),
      .b        (cap_b)
   );

   // The shadow with this cycle's capture folded in; a row-7 commit copies
   // this view so the last row lands in the frame on the same edge.
   always_comb begin
      shadow_upd = shadow;
      if (capture) begin
         shadow_upd[cap_row] = decode_cols(cap_r, cap_g, cap_b);
      end
   end

   always_comb begin
      state_next    = state;
      expected_next = expected;
      seq_inc       = 1'b0;
      commit        = 1'b0;
      if (!cap_en) begin
         state_next    = HUNT;
         expected_next = '0;
      end else if (capture) begin
         case (state)
            HUNT: begin
               if (cap_row == 3'd0) begin
                  state_next    = SWEEP;
                  expected_next = 3'd1;
               end
            end
            SWEEP: begin
               if (cap_row == expected) begin
                  expected_next = expected + 3'd1;
                  if (cap_row == 3'd7) begin
                     commit     = 1'b1;
                     state_next = HUNT;
                  end
               end else begin
                  seq_inc = 1'b1;
                  if (cap_row == 3'd0) begin
                     expected_next = 3'd1;
                  end else begin
                     state_next = HUNT;
                  end
               end
            end
            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state    <= HUNT;
         expected <= '0;
      end else begin
         state    <= state_next;
         expected <= expected_next;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         shadow          <= '0;
         frame           <= '0;
         frame_valid_q   <= 1'b0;
         frame_changed_q <= 1'b0;
         frame_count_q   <= '0;
         seq_err_q       <= '0;
      end else begin
         shadow          <= shadow_upd;
         frame_valid_q   <= commit;
         frame_changed_q <= commit && (shadow_upd != frame);
         if (commit) begin
            frame         <= shadow_upd;
            frame_count_q <= frame_count_q + CNT_W'(1);
         end
         if (seq_inc && (seq_err_q != '1)) begin
            seq_err_q <= seq_err_q + CNT_W'(1);
         end
      end
   end

   assign bus.rd_r          = frame[bus.rd_row].r;
   assign bus.rd_g          = frame[bus.rd_row].g;
   assign bus.rd_b          = frame[bus.rd_row].b;
   assign bus.frame_valid   = frame_valid_q;
   assign bus.frame_changed = frame_changed_q;
   assign bus.frame_count   = frame_count_q;
   assign bus.seq_err       = seq_err_q;

endmodule

// File: tb/tb_led_scan_capture.sv
// Scoreboard bench for led_scan_capture: a dwell-level reference model queues
// expected commits, and a monitor checks every frame_valid against that queue.
module tb_led_scan_capture;
   import led_matrix_pkg::*;

   localparam int SETTLE = 4;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic [191:0]     frame;
      logic             changed;
      logic [CNT_W-1:0] count;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   led_scan_capture_if #(.CNT_W(CNT_W)) bus ();

   led_scan_capture #(
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   exp_t         exp_q[$];
   logic [191:0] snap;
   logic [23:0]  pat [8];

   // Reference model: rows captured at dwell level, sweep rules applied to them.
   logic [23:0]  m_shadow [8];
   logic [191:0] m_frame;
   bit           m_hunt;
   int           m_expect;
   int           m_count;
   int           m_seq;
   bit           m_have_prev;
   logic [27:0]  m_prev;
   int           m_run;
   bit           m_capt;

   task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_shadow[i] = '0;
      m_frame     = '0;
      m_hunt      = 1'b1;
      m_expect    = 0;
      m_count     = 0;
      m_seq       = 0;
      m_have_prev = 1'b0;
      m_prev      = '0;
      m_run       = 0;
      m_capt      = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_capture(input int row, input logic [23:0] px);
      logic [191:0] nf;
      m_shadow[row] = px;
      if (m_hunt) begin
         if (row == 0) begin
            m_hunt   = 1'b0;
            m_expect = 1;
         end
      end else if (row == m_expect) begin
         if (row == 7) begin
            for (int i = 0; i < 8; i++) nf[i*24 +: 24] = m_shadow[i];
            m_count++;
            exp_q.push_back('{frame: nf, changed: (nf != m_frame), count: CNT_W'(m_count)});
            m_frame = nf;
            m_hunt  = 1'b1;
         end else begin
            m_expect++;
         end
      end else begin
         if (m_seq < 65535) m_seq++;
         if (row == 0) m_expect = 1;
         else m_hunt = 1'b1;
      end
   endtask

   task automatic model_dwell(input bit en, input logic [2:0] row, input logic [7:0] r,
                              input logic [7:0] g, input logic [7:0] b, input int len);
      logic [27:0] v;
      v = {en, row, r, g, b};
      if (m_have_prev && (v == m_prev)) begin
         m_run += len;
      end else begin
         m_run  = len;
         m_capt = 1'b0;
      end
      m_prev      = v;
      m_have_prev = 1'b1;
      if (!en) begin
         m_hunt = 1'b1;
      end else if (!m_capt && (m_run >= SETTLE)) begin
         m_capt = 1'b1;
         model_capture(int'(row), {~r, ~g, ~b});
      end
   endtask

   task automatic applyStimulus(input bit en, input logic [2:0] row, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b, input int len);
      bus.scan_en  = en;
      bus.scan_row = row;
      bus.scan_r   = r;
      bus.scan_g   = g;
      bus.scan_b   = b;
      model_dwell(en, row, r, g, b, len);
      repeat (len) @(negedge clk);
   endtask

   task automatic sweep_rows(input int first, input int last, input int len);
      for (int i = first; i <= last; i++) begin
         applyStimulus(1'b1, 3'(i), pat[i][23:16], pat[i][15:8], pat[i][7:0], len);
      end
   endtask

   task automatic load_onehot_pattern();
      logic [7:0] oh;
      for (int i = 0; i < 8; i++) begin
         oh     = 8'h01 << i;
         pat[i] = {~oh, 8'hFF, 8'hFF};
      end
   endtask

   task automatic sample_quiet();
      @(negedge clk);
      #9;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.scan_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 6);
   endtask

   task automatic finish_phase(input string name);
      applyStimulus(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 16);
      sample_quiet();
      checkOutput({name, " frame_count"}, bus.frame_count, CNT_W'(m_count));
      checkOutput({name, " seq_err"}, bus.seq_err, CNT_W'(m_seq));
      checkOutput({name, " frames outstanding"}, exp_q.size(), 0);
      checkOutput({name, " frame contents"}, snap, m_frame);
   endtask

   // Monitor: refresh the read-port snapshot every cycle and score each commit.
   initial begin
      logic             fv;
      logic             fc;
      logic [CNT_W-1:0] cnt;
      exp_t             e;
      bus.rd_row = '0;
      forever begin
         @(negedge clk);
         fv  = bus.frame_valid;
         fc  = bus.frame_changed;
         cnt = bus.frame_count;
         for (int i = 0; i < 8; i++) begin
            bus.rd_row = 3'(i);
            #1;
            snap[i*24 +: 24] = {bus.rd_r, bus.rd_g, bus.rd_b};
         end
         if (fv) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected frame_valid: got 1, required 0 (count %0d)", cnt);
            end else begin
               e = exp_q.pop_front();
               checkOutput("commit frame_changed", fc, e.changed);
               checkOutput("commit frame_count", cnt, e.count);
               checkOutput("commit frame contents", snap, e.frame);
            end
         end else if (fc) begin
            checks++;
            errors++;
            $display("[TB] FAIL stray frame_changed: got 1, required 0");
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not reach the end, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         sel;
      int         len;
      logic [2:0] rw;

      bus.scan_en  = 1'b0;
      bus.scan_row = '0;
      bus.scan_r   = 8'hFF;
      bus.scan_g   = 8'hFF;
      bus.scan_b   = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);

      sample_quiet();
      checkOutput("reset frame_valid", bus.frame_valid, 1'b0);
      checkOutput("reset frame_changed", bus.frame_changed, 1'b0);
      checkOutput("reset frame_count", bus.frame_count, '0);
      checkOutput("reset seq_err", bus.seq_err, '0);
      checkOutput("reset frame contents", snap, '0);

      $display("[TB] clean sweep");
      do_reset();
      load_onehot_pattern();
      sweep_rows(0, 7, 10);
      finish_phase("clean");
      checkOutput("clean count is one", bus.frame_count, CNT_W'(1));
      checkOutput("clean row 3", snap[3*24 +: 24], 24'h080000);

      $display("[TB] glitch reject");
      do_reset();
      sweep_rows(0, 1, 10);
      sweep_rows(2, 2, SETTLE - 1);
      sweep_rows(3, 7, 10);
      finish_phase("glitch");
      checkOutput("glitch seq_err is one", bus.seq_err, CNT_W'(1));
      checkOutput("glitch no commit", bus.frame_count, '0);

      $display("[TB] out of sequence");
      do_reset();
      sweep_rows(0, 2, 10);
      sweep_rows(5, 7, 10);
      sweep_rows(0, 7, 10);
      finish_phase("outseq");
      checkOutput("outseq seq_err is one", bus.seq_err, CNT_W'(1));
      checkOutput("outseq count is one", bus.frame_count, CNT_W'(1));

      $display("[TB] identical frames");
      do_reset();
      for (int i = 0; i < 8; i++) pat[i] = 24'($urandom);
      sweep_rows(0, 7, 8);
      sweep_rows(0, 7, 8);
      finish_phase("identical");
      checkOutput("identical count is two", bus.frame_count, CNT_W'(2));

      $display("[TB] scan_en drop");
      do_reset();
      for (int i = 0; i < 8; i++) pat[i] = 24'($urandom);
      sweep_rows(0, 7, 8);
      for (int i = 0; i < 8; i++) pat[i] = 24'($urandom);
      sweep_rows(0, 4, 10);
      applyStimulus(1'b0, 3'd4, pat[4][23:16], pat[4][15:8], pat[4][7:0], 10);
      sweep_rows(5, 7, 10);
      finish_phase("endrop");
      checkOutput("endrop seq_err is zero", bus.seq_err, '0);
      checkOutput("endrop count is one", bus.frame_count, CNT_W'(1));

      $display("[TB] reset mid-sweep");
      do_reset();
      load_onehot_pattern();
      sweep_rows(0, 4, 10);
      applyStimulus(1'b1, 3'd5, pat[5][23:16], pat[5][15:8], pat[5][7:0], 5);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      sample_quiet();
      checkOutput("midreset frame_valid", bus.frame_valid, 1'b0);
      checkOutput("midreset frame_count", bus.frame_count, '0);
      checkOutput("midreset seq_err", bus.seq_err, '0);
      checkOutput("midreset frame contents", snap, '0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 6);
      sweep_rows(0, 7, 10);
      finish_phase("midreset");
      checkOutput("midreset count is one", bus.frame_count, CNT_W'(1));

      $display("[TB] randomized sweeps");
      do_reset();
      for (int s = 0; s < 30; s++) begin
         if ($urandom_range(0, 3) != 0) begin
            for (int i = 0; i < 8; i++) pat[i] = 24'($urandom);
         end
         for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 24);
            len = $urandom_range(SETTLE, SETTLE + 6);
            rw  = 3'(i);
            if (sel == 0) begin
               rw = 3'($urandom_range(0, 7));
            end else if (sel == 1) begin
               len = $urandom_range(1, SETTLE - 1);
            end
            applyStimulus(1'b1, rw, pat[i][23:16], pat[i][15:8], pat[i][7:0], len);
            if (sel == 2) begin
               applyStimulus(1'b0, rw, pat[i][23:16], pat[i][15:8], pat[i][7:0], $urandom_range(1, 3));
            end
         end
      end
      finish_phase("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_scan_capture.md
Name: led_scan_capture

Overview:
- Receive-side counterpart of the 8x8 RGB matrix row-scan driver.
- Watches the multiplexed scan bus (row select plus active-low R/G/B columns) and rebuilds complete frames in an internal buffer.
- Exposes the buffer through a random-access read port, with frame-complete and frame-changed pulses.
- Used as an on-chip display mirror and as a scoreboard tap in the game testbench.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical synchronized samples needed before a row is accepted (range 2..255).
- CNT_W, 16, width of the frame counter and the sequence-error counter.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  reset, asynchronous, active-low
- scan_en  input  1  display enable from the driver; low means the bus is invalid
- scan_row  input  3  row currently driven
- scan_r  input  8  red column data, active-low
- scan_g  input  8  green column data, active-low
- scan_b  input  8  blue column data, active-low
- rd_row  input  3  read-port row select
- rd_r  output  8  red bits of committed frame row rd_row, active-high
- rd_g  output  8  green bits, active-high
- rd_b  output  8  blue bits, active-high
- frame_valid  output  1  one-cycle pulse when a new frame is committed
- frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when the new frame differs from the previous one
- frame_count  output  CNT_W  committed frames, wraps modulo 2^CNT_W
- seq_err  output  CNT_W  out-of-sequence row count, saturates at all-ones

Behaviour:
- Clock, reset and synchronizers
  - One clock domain, CLK. The scan bus is asynchronous to CLK.
  - All 28 scan bits (scan_en, scan_row, scan_r/g/b) pass through a 2-flop synchronizer.
  - Reset is asynchronous and active-low. The RST_N release edge is synchronized internally.
- Reset values
  - Frame buffer and shadow buffer: all 0, so rd_r/g/b read all-off.
  - frame_valid = 0, frame_changed = 0, frame_count = 0, seq_err = 0.
  - FSM = HUNT, stable counter = 0, captured flag = 0.
- Settle filter
  - The synchronized 27-bit {row, r, g, b} vector is compared each cycle with its previous value.
  - Any difference clears the stable counter and the captured flag.
  - When the counter reaches SETTLE_CYCLES-1 with the captured flag clear, a capture event fires and the flag is set.
  - Result: at most one capture per dwell.
  - Latency from a bus change to capture = 2 (sync) + SETTLE_CYCLES cycles.
- Capture inverts the column bits and writes {~r, ~g, ~b} to shadow[row].
- FSM
  - HUNT: waits for a capture with row == 0. On that capture, store shadow[0], set expected = 1, go to SWEEP.
  - SWEEP, capture with row == expected:
    - Store the row; expected increments.
    - If row == 7, commit the shadow to the frame buffer in the same cycle and go to HUNT.
  - SWEEP, capture with row != expected:
    - seq_err increments (saturating).
    - If row == 0, restart the sweep (store row 0, expected = 1, stay in SWEEP). Otherwise go to HUNT.
- Commit timing
  - On the cycle after the row-7 capture, frame_valid = 1 and frame_count has incremented.
  - frame_changed = 1 in that same cycle if and only if the new 192-bit frame differs from the old one.
  - rd_* reflect the new frame from that cycle onward.
- scan_en (synchronized) low
  - Aborts any sweep: go to HUNT, clear the stable counter.
  - No error is counted and no commit occurs.
  - The frame buffer keeps its last committed frame.
- Read port is combinational from the frame buffer. There is no read/commit hazard because the commit is a single-cycle register update.
- Row 7 to row 0 wrap is the normal sweep boundary. It is never an error.
- Reset asserted mid-sweep clears everything immediately, including the partial shadow. No frame_valid is produced.

Decomposition:
- Shared package led_matrix_pkg, containing:
  - ROWS = 8, COLS = 8;
  - typedef row_idx_t (3-bit);
  - typedef rgb_row_t (struct of three 8-bit fields);
  - the FSM state enum {HUNT, SWEEP}.
- One natural sub-module: scan_settle_filter. It holds the synchronizer, stable counter and captured flag, and outputs a capture strobe plus the sampled row/data.

Test Plan:
- Clean sweep: rows 0..7, each held 10 cycles, row r drives scan_r = ~(8'h01<<r) and g = b = 8'hFF.
  - Expect exactly one frame_valid.
  - frame_count = 1.
  - rd_row = 3 gives rd_r = 8'h08, rd_g = rd_b = 0.
- Glitch reject, SETTLE_CYCLES = 4: hold row 2 for 3 cycles between rows 1 and 3 of a sweep.
  - Row 2 is not captured.
  - The row-3 capture counts as out of sequence: seq_err = 1, no frame_valid.
- Out of sequence: sequence 0,1,2,5,...
  - seq_err = 1 and the FSM returns to HUNT.
  - The next clean 0..7 sweep commits: frame_count = 1.
- Identical frames: two identical clean sweeps.
  - frame_valid pulses twice.
  - frame_changed pulses only on the first, since the first frame differs from the all-0 reset frame.
- scan_en drop: deassert scan_en during row 4.
  - seq_err = 0, no commit, rd_* still show the previous frame.
- Reset mid-sweep: assert RST_N = 0 during row 5, then release and run a clean sweep.
  - During reset: outputs read 0.
  - After the clean sweep: frame_valid fires once and frame_count = 1.
